// File: rtl/snes_address_map_if.sv
// rtl/snes_address_map_if.sv - bus bundle for the SNES/AVR cartridge address mapper
interface snes_address_map_if;
  logic [3:0]  MAPPER;
  logic [23:0] SNES_ADDR;
  logic        SNES_CS;
  logic        AVR_ENA;
  logic        MODE;
  logic [23:0] AVR_ADDR;
  logic [23:0] SAVERAM_MASK;
  logic [23:0] ROM_MASK;
  logic [19:0] SRAM_ADDR;
  logic [3:0]  ROM_SEL;
  logic        IS_ROM;
  logic        IS_SAVERAM;
  logic        SRAM_ADDR0;

  modport master (
    output MAPPER, SNES_ADDR, SNES_CS, AVR_ENA, MODE, AVR_ADDR, SAVERAM_MASK, ROM_MASK,
    input  SRAM_ADDR, ROM_SEL, IS_ROM, IS_SAVERAM, SRAM_ADDR0
  );

  modport slave (
    input  MAPPER, SNES_ADDR, SNES_CS, AVR_ENA, MODE, AVR_ADDR, SAVERAM_MASK, ROM_MASK,
    output SRAM_ADDR, ROM_SEL, IS_ROM, IS_SAVERAM, SRAM_ADDR0
  );
endinterface

// File: rtl/snes_address_map.sv
// rtl/snes_address_map.sv - HiROM/LoROM/linear decode to registered SRAM word address and chip selects
// Optional macro SNES_ADDRESS_MAP_ROM_MASK_EN: apply ROM_MASK to the ROM physical address.
module snes_address_map (
  input  logic                CLK,
  input  logic                RST,
  snes_address_map_if.slave   bus
);

  logic [23:0] a;
  logic        dec_rom;
  logic        dec_sav;
  logic        is_rom;
  logic        is_sav;
  logic        linear;
  logic        avr_path;
  logic [22:0] rom_p_raw;
  logic [22:0] rom_p;
  logic [22:0] sav_off;
  logic [22:0] snes_p;
  logic [22:0] p;
  logic [3:0]  sel_n;
  logic        unused_bits;

  assign a = bus.SNES_ADDR;

  always_comb begin
    dec_rom   = 1'b0;
    dec_sav   = 1'b0;
    linear    = 1'b0;
    rom_p_raw = 23'd0;
    sav_off   = 23'd0;
    case (bus.MAPPER)
      4'd0: begin
        dec_rom   = a[22] | a[15];
        dec_sav   = ~a[22] & a[21] & a[14] & a[13] & ~a[15];
        rom_p_raw = {1'b0, a[21:0]};
        sav_off   = {5'd0, a[20:16], a[12:0]};
      end
      4'd1: begin
        dec_rom   = a[15];
        // Banks 7E/7F are WRAM, not save RAM, in the low half of the map.
        dec_sav   = (a[22:20] == 3'b111) & ~a[15] & ~(~a[23] & (a[22:17] == 6'b111111));
        rom_p_raw = {1'b0, a[22:16], a[14:0]};
        sav_off   = {4'd0, a[19:16], a[14:0]};
      end
      default: linear = 1'b1;
    endcase
  end

`ifdef SNES_ADDRESS_MAP_ROM_MASK_EN
  assign rom_p = rom_p_raw & bus.ROM_MASK[22:0];
`else
  assign rom_p = rom_p_raw;
`endif

  assign is_sav   = dec_sav;
  assign is_rom   = dec_rom & ~dec_sav;
  assign avr_path = ~bus.AVR_ENA | bus.MODE;

  always_comb begin
    if (linear)
      snes_p = a[22:0];
    else if (is_sav)
      snes_p = 23'h600000 | (sav_off & bus.SAVERAM_MASK[22:0]);
    else
      snes_p = rom_p;

    p     = avr_path ? bus.AVR_ADDR[22:0] : snes_p;
    sel_n = ~(4'b0001 << p[22:21]);
    if (!avr_path && bus.SNES_CS && !is_sav)
      sel_n = 4'b1111;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      bus.SRAM_ADDR  <= 20'd0;
      bus.SRAM_ADDR0 <= 1'b0;
      bus.ROM_SEL    <= 4'b1111;
      bus.IS_ROM     <= 1'b0;
      bus.IS_SAVERAM <= 1'b0;
    end else begin
      bus.SRAM_ADDR  <= p[20:1];
      bus.SRAM_ADDR0 <= p[0];
      bus.ROM_SEL    <= sel_n;
      bus.IS_ROM     <= is_rom;
      bus.IS_SAVERAM <= is_sav;
    end
  end

  assign unused_bits = &{1'b0, bus.AVR_ADDR[23], bus.SAVERAM_MASK[23], bus.ROM_MASK};

endmodule

// File: tb/tb_snes_address_map.sv
// tb/tb_snes_address_map.sv - scoreboard bench for snes_address_map against an arithmetic reference model
module tb_snes_address_map;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  snes_address_map_if bus();

  snes_address_map dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [19:0] sram;
    logic [3:0]  sel;
    logic        rom;
    logic        sav;
    logic        a0;
    logic        chk_addr;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: byte address built from bank/offset arithmetic.
  function automatic exp_t model(input int unsigned mapper, input int unsigned a, input bit cs,
                                 input bit ena, input bit mode, input int unsigned avr,
                                 input int unsigned smask, input int unsigned rmask);
    exp_t        e;
    bit          rom = 0;
    bit          sav = 0;
    bit          avr_path;
    int unsigned rom_p = 0;
    int unsigned off = 0;
    int unsigned p;
    int unsigned chip;
    e.chk_addr = 1;
    if (mapper == 0) begin
      rom   = (((a >> 22) & 1) != 0) || ((a & 'h8000) != 0);
      sav   = (((a >> 21) & 3) == 1) && ((a & 'hE000) == 'h6000);
      rom_p = a % (1 << 22);
      off   = ((a >> 16) & 'h1F) * 'h2000 + a % 'h2000;
    end else if (mapper == 1) begin
      rom   = (a & 'h8000) != 0;
      sav   = (((a >> 20) & 7) == 7) && ((a & 'h8000) == 0) &&
              !((a < 'h800000) && (((a >> 17) & 'h3F) == 'h3F));
      rom_p = ((a >> 16) & 'h7F) * 'h8000 + a % 'h8000;
      off   = ((a >> 16) & 'hF) * 'h8000 + a % 'h8000;
    end
`ifdef SNES_ADDRESS_MAP_ROM_MASK_EN
    rom_p = rom_p & rmask;
`else
    rmask = rmask;
`endif
    if (sav) rom = 0;
    avr_path = !ena || mode;
    if (avr_path) p = avr % (1 << 23);
    else if (mapper >= 2) p = a % (1 << 23);
    else if (sav) p = ('h600000 | (off & smask)) % (1 << 23);
    else begin
      p = rom_p;
      if (!rom) e.chk_addr = 0;
    end
    chip  = p >> 21;
    e.sel = 4'hF ^ (4'h1 << chip);
    if (!avr_path && cs && !sav) e.sel = 4'hF;
    e.sram = 20'((p >> 1) % (1 << 20));
    e.a0   = p[0];
    e.rom  = rom;
    e.sav  = sav;
    return e;
  endfunction

  task automatic apply(input logic [3:0] mapper, input logic [23:0] a, input bit cs, input bit ena,
                       input bit mode, input logic [23:0] avr, input logic [23:0] smask,
                       input logic [23:0] rmask, input bit directed, input exp_t de);
    @(negedge CLK);
    bus.MAPPER       = mapper;
    bus.SNES_ADDR    = a;
    bus.SNES_CS      = cs;
    bus.AVR_ENA      = ena;
    bus.MODE         = mode;
    bus.AVR_ADDR     = avr;
    bus.SAVERAM_MASK = smask;
    bus.ROM_MASK     = rmask;
    if (directed) q.push_back(de);
    else q.push_back(model(mapper, a, cs, ena, mode, avr, smask, rmask));
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_sram"}, 32'(bus.SRAM_ADDR), 32'h0);
    check({tag, "_a0"},   32'(bus.SRAM_ADDR0), 32'h0);
    check({tag, "_sel"},  32'(bus.ROM_SEL), 32'hF);
    check({tag, "_rom"},  32'(bus.IS_ROM), 32'h0);
    check({tag, "_sav"},  32'(bus.IS_SAVERAM), 32'h0);
  endtask

  task automatic mid_reset();
    @(posedge CLK);
    #3;
    RST = 1'b1;
    #1;
    check_reset("midrst");
    @(posedge CLK);
    #1;
    check("midrst_hold_sel", 32'(bus.ROM_SEL), 32'hF);
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic random_burst(input int n);
    logic [23:0] a;
    logic [3:0]  m;
    for (int i = 0; i < n; i++) begin
      m = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(2, 15)) : 4'($urandom_range(0, 1));
      a = 24'($urandom);
      case ($urandom_range(0, 3))
        0: begin a[22] = 1'b0; a[21] = 1'b1; a[15] = 1'b0; a[14:13] = 2'b11; end
        1: begin a[22:20] = 3'b111; a[15] = 1'b0; end
        default: ;
      endcase
      apply(m, a, bit'($urandom_range(0, 1)), ($urandom_range(0, 7) != 0), ($urandom_range(0, 3) == 0),
            24'($urandom), ($urandom_range(0, 1) != 0) ? 24'hFFFFFF : 24'($urandom),
            ($urandom_range(0, 1) != 0) ? 24'hFFFFFF : 24'($urandom), 1'b0, '{default: 0});
    end
  endtask

  // Monitor: each registered output reflects the inputs set before the previous edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (!RST && q.size() > 0) begin
        e = q.pop_front();
        check("is_rom", 32'(bus.IS_ROM), 32'(e.rom));
        check("is_saveram", 32'(bus.IS_SAVERAM), 32'(e.sav));
        check("rom_sel", 32'(bus.ROM_SEL), 32'(e.sel));
        if (e.chk_addr) begin
          check("sram_addr", 32'(bus.SRAM_ADDR), 32'(e.sram));
          check("sram_addr0", 32'(bus.SRAM_ADDR0), 32'(e.a0));
        end
      end
    end
  end

  initial begin
    bus.MAPPER       = 4'd0;
    bus.SNES_ADDR    = 24'h0;
    bus.SNES_CS      = 1'b1;
    bus.AVR_ENA      = 1'b1;
    bus.MODE         = 1'b0;
    bus.AVR_ADDR     = 24'h0;
    bus.SAVERAM_MASK = 24'hFFFFFF;
    bus.ROM_MASK     = 24'hFFFFFF;
    #13;
    check_reset("reset");
    @(negedge CLK);
    RST = 1'b0;

    apply(4'd0, 24'hC12345, 1'b0, 1'b1, 1'b0, 24'h0, 24'hFFFFFF, 24'hFFFFFF, 1'b1,
          '{20'h091A2, 4'b1110, 1'b1, 1'b0, 1'b1, 1'b1});
    apply(4'd1, 24'h018000, 1'b0, 1'b1, 1'b0, 24'h0, 24'hFFFFFF, 24'hFFFFFF, 1'b1,
          '{20'h04000, 4'b1110, 1'b1, 1'b0, 1'b0, 1'b1});
    apply(4'd1, 24'h700010, 1'b1, 1'b1, 1'b0, 24'h0, 24'h001FFF, 24'hFFFFFF, 1'b1,
          '{20'h00008, 4'b0111, 1'b0, 1'b1, 1'b0, 1'b1});
    apply(4'd1, 24'h000000, 1'b1, 1'b0, 1'b0, 24'h234567, 24'hFFFFFF, 24'hFFFFFF, 1'b1,
          '{20'h1A2B3, 4'b1101, 1'b0, 1'b0, 1'b1, 1'b1});
    apply(4'd1, 24'h000000, 1'b1, 1'b1, 1'b0, 24'h234567, 24'hFFFFFF, 24'hFFFFFF, 1'b1,
          '{20'h0, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0});
`ifdef SNES_ADDRESS_MAP_ROM_MASK_EN
    apply(4'd0, 24'hFF8000, 1'b0, 1'b1, 1'b0, 24'h0, 24'hFFFFFF, 24'h0FFFFF, 1'b1,
          '{20'h7C000, 4'b1110, 1'b1, 1'b0, 1'b0, 1'b1});
`else
    apply(4'd0, 24'hFF8000, 1'b0, 1'b1, 1'b0, 24'h0, 24'hFFFFFF, 24'h0FFFFF, 1'b1,
          '{20'hFC000, 4'b1101, 1'b1, 1'b0, 1'b0, 1'b1});
`endif
    mid_reset();
    random_burst(300);
    mid_reset();
    random_burst(300);

    repeat (3) @(posedge CLK);
    #2;
    check("scoreboard_drained", 32'(q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
